dma_rd_burst_gen: RTL and testbench

- Parametrised read-command generator for weight/feature DMA. Successor to the fixed-burst weight command generator.
- Splits a transfer of total_beats bus beats into AXI-style read bursts at a runtime-selected burst size.
- Tracks outstanding bursts against a credit limit and reports completion only after every burst has returned its last response beat.
- Sits between the CSR block and MCIF read port.

---
 rtl/dma_rd_burst_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_dma_rd_burst_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rd_burst_gen.sv
// dma_rd_burst_gen: read-command generator for weight/feature DMA.
// Splits a transfer of total_beats bus beats into read bursts of a runtime-
// selected size. It tracks in-flight bursts against a credit limit, and it
// pulses done once every burst has returned its last response beat.
// Optional feature macro: DMA_RD_4K_SPLIT_EN. When it is defined, no burst
// crosses a 4 KB address boundary.
module dma_rd_burst_gen #(
   parameter int ADDR_W          = 32,
   parameter int LOG2_BEAT_BYTES = 4,
   parameter int LOG2_MAX_BURST  = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 24
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [ADDR_W-1:0]                base_addr,
   input  logic [CNT_W-1:0]                 total_beats,
   input  logic [LOG2_MAX_BURST:0]          burst_beats,
   output logic                             rd_req_vld,
   input  logic                             rd_req_rdy,
   output logic [LOG2_MAX_BURST+ADDR_W-1:0] rd_req_pd,
   input  logic                             rd_rsp_last,
   output logic                             busy,
   output logic                             done,
   output logic [7:0]                       outstanding
);

   // A burst length in beats needs one bit more than cmd_len (1..2^LOG2_MAX_BURST).
   localparam int BL_W = LOG2_MAX_BURST + 1;
   localparam int PD_W = LOG2_MAX_BURST + ADDR_W;
   localparam logic [BL_W-1:0]   MAX_BURST  = BL_W'(1) << LOG2_MAX_BURST;
   localparam logic [7:0]        MAX_OUT    = 8'(MAX_OUTSTANDING);
   localparam logic [ADDR_W-1:0] ALIGN_MASK =
      ~((ADDR_W'(1) << LOG2_BEAT_BYTES) - ADDR_W'(1));

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [CNT_W-1:0]    remaining_reg, remaining_next;
   logic [BL_W-1:0]     burst_cfg_reg, burst_cfg_next;
   logic [BL_W-1:0]     cur_beats_reg, cur_beats_next;
   logic [7:0]          outstanding_reg, outstanding_next;
   logic                vld_reg, vld_next;
   logic [PD_W-1:0]     pd_reg, pd_next;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;

   // Shared combinational terms
   logic                hs;
   logic                rsp_dec;
   logic                drain_exit;
   logic [ADDR_W-1:0]   addr_upd;
   logic [CNT_W-1:0]    rem_upd;
   logic [7:0]          out_upd;
   logic [BL_W-1:0]     cfg_clamped;
   logic [BL_W-1:0]     len_a;
   logic [BL_W-1:0]     burst_len;
`ifdef DMA_RD_4K_SPLIT_EN
   logic [12:0]         to4k_bytes;
   logic [12:0]         to4k_beats;
`endif

   // Handshake and response events, plus the address, remaining count and
   // credit as they will stand after this cycle's events.
   always_comb begin
      hs         = vld_reg & rd_req_rdy;
      rsp_dec    = rd_rsp_last & (outstanding_reg != 8'd0);
      drain_exit = (outstanding_reg == 8'd0) ||
                   ((outstanding_reg == 8'd1) && rd_rsp_last);
      addr_upd   = addr_reg;
      rem_upd    = remaining_reg;
      if (hs) begin
         addr_upd = addr_reg + (ADDR_W'(cur_beats_reg) << LOG2_BEAT_BYTES);
         rem_upd  = remaining_reg - CNT_W'(cur_beats_reg);
      end
      case ({hs, rsp_dec})
         2'b10:   out_upd = outstanding_reg + 8'd1;
         2'b01:   out_upd = outstanding_reg - 8'd1;
         default: out_upd = outstanding_reg;
      endcase
   end

   // A burst size of zero, or one above the maximum, selects the maximum burst.
   always_comb begin
      cfg_clamped = burst_beats;
      if ((burst_beats == '0) || (burst_beats > MAX_BURST)) begin
         cfg_clamped = MAX_BURST;
      end
   end

   // The next burst length is the smallest of: the remaining beats, the
   // configured burst size, and (when splitting) the beats left to the 4 KB boundary.
   always_comb begin
      len_a = burst_cfg_reg;
      if (rem_upd < CNT_W'(burst_cfg_reg)) begin
         len_a = BL_W'(rem_upd);
      end
`ifdef DMA_RD_4K_SPLIT_EN
      // The address is beat-aligned, so the byte distance divides evenly.
      to4k_bytes = 13'h1000 - {1'b0, addr_upd[11:0]};
      to4k_beats = to4k_bytes >> LOG2_BEAT_BYTES;
      burst_len  = len_a;
      if (to4k_beats < 13'(len_a)) begin
         burst_len = BL_W'(to4k_beats);
      end
`else
      burst_len = len_a;
`endif
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start && (total_beats != '0)) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (hs && (rem_upd == '0)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_exit) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM output logic. This block computes the next values of the
   // registered command interface, the status outputs and the datapath.
   always_comb begin
      addr_next        = addr_reg;
      remaining_next   = remaining_reg;
      burst_cfg_next   = burst_cfg_reg;
      cur_beats_next   = cur_beats_reg;
      outstanding_next = out_upd;
      vld_next         = 1'b0;
      pd_next          = pd_reg;
      done_next        = 1'b0;
      busy_next        = (state_next != IDLE);
      case (state_reg)
         IDLE: begin
            if (start) begin
               addr_next      = base_addr & ALIGN_MASK;
               remaining_next = total_beats;
               burst_cfg_next = cfg_clamped;
               // An empty transfer completes at once and issues nothing.
               done_next      = (total_beats == '0);
            end
         end
         ISSUE: begin
            addr_next      = addr_upd;
            remaining_next = rem_upd;
            if (vld_reg && !rd_req_rdy) begin
               // A command is offered but not yet accepted: hold it unchanged.
               vld_next = 1'b1;
            end else if ((rem_upd != '0) && (out_upd < MAX_OUT)) begin
               // Idle or just accepted: offer the next burst if credit allows.
               vld_next       = 1'b1;
               pd_next        = {LOG2_MAX_BURST'(burst_len - BL_W'(1)), addr_upd};
               cur_beats_next = burst_len;
            end
         end
         DRAIN: begin
            done_next = drain_exit;
         end
         default: begin
            done_next = 1'b0;
         end
      endcase
   end

   // Datapath and output registers. Reset drops any transfer in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg        <= '0;
         remaining_reg   <= '0;
         burst_cfg_reg   <= MAX_BURST;
         cur_beats_reg   <= '0;
         outstanding_reg <= 8'd0;
         vld_reg         <= 1'b0;
         pd_reg          <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         addr_reg        <= addr_next;
         remaining_reg   <= remaining_next;
         burst_cfg_reg   <= burst_cfg_next;
         cur_beats_reg   <= cur_beats_next;
         outstanding_reg <= outstanding_next;
         vld_reg         <= vld_next;
         pd_reg          <= pd_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
      end
   end

   assign rd_req_vld  = vld_reg;
   assign rd_req_pd   = pd_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign outstanding = outstanding_reg;

endmodule

// File: tb/tb_dma_rd_burst_gen.sv
// tb_dma_rd_burst_gen: directed bench for dma_rd_burst_gen. The design runs
// with a credit limit of 2 so that credit stalls can be seen.
module tb_dma_rd_burst_gen;

   localparam int ADDR_W = 32;
   localparam int LB     = 4;
   localparam int LM     = 4;
   localparam int MAXO   = 2;
   localparam int CNT_W  = 24;
   localparam int PD_W   = LM + ADDR_W;
`ifdef DMA_RD_4K_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  total_beats = '0;
   logic [LM:0]       burst_beats = '0;
   logic              rd_req_vld;
   logic              rd_req_rdy = 1'b0;
   logic [PD_W-1:0]   rd_req_pd;
   logic              rd_rsp_last = 1'b0;
   logic              busy;
   logic              done;
   logic [7:0]        outstanding;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ncmd, done_cyc, last_rsp_cyc, busy_bad, hs_cnt, hold_bad;
   logic [PD_W-1:0] pds [0:7];
   logic [PD_W-1:0] pd_first;

   always #5 clk = ~clk;

   dma_rd_burst_gen #(
      .ADDR_W(ADDR_W), .LOG2_BEAT_BYTES(LB), .LOG2_MAX_BURST(LM),
      .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .total_beats(total_beats), .burst_beats(burst_beats),
      .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_pd(rd_req_pd),
      .rd_rsp_last(rd_rsp_last), .busy(busy), .done(done),
      .outstanding(outstanding)
   );

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   function automatic logic [PD_W-1:0] mkpd(input logic [LM-1:0] len, input logic [ADDR_W-1:0] a);
      return {len, a};
   endfunction

   // Advance one cycle. Afterwards, outputs are stable and inputs may be driven.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_xfer(input logic [31:0] base, input logic [23:0] total, input logic [4:0] burst);
      base_addr   = base;
      total_beats = total;
      burst_beats = burst;
      start       = 1'b1;
      step();
      start       = 1'b0;
   endtask

   // Accept every command. Return rd_rsp_last dly cycles after each handshake.
   // pre bursts that are already in flight return in the next cycles.
   task automatic service(input string tag, input int dly, input int pre, input int budget);
      int sched[$];
      ncmd = 0; done_cyc = -1; last_rsp_cyc = -1; busy_bad = 0;
      for (int k = 0; k < pre; k++) sched.push_back(cyc + k);
      rd_req_rdy = 1'b1;
      for (int i = 0; i < budget && done_cyc < 0; i++) begin
         rd_rsp_last = 1'b0;
         if (sched.size() > 0 && sched[0] == cyc) begin
            void'(sched.pop_front());
            rd_rsp_last  = 1'b1;
            last_rsp_cyc = cyc;
         end
         if (rd_req_vld) begin
            if (ncmd < 8) pds[ncmd] = rd_req_pd;
            ncmd++;
            sched.push_back(cyc + dly);
         end
         if (done) done_cyc = cyc;
         else if (!busy) busy_bad++;
         step();
      end
      rd_rsp_last = 1'b0;
      rd_req_rdy  = 1'b0;
      check({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step(); step();
      check("rst_vld", rd_req_vld, 0);
      check("rst_pd", rd_req_pd, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out", outstanding, 0);
      rst_n = 1'b1;
      step();

      // T1: three bursts. Completion follows the third response.
      start_xfer(32'h1000, 24'd40, 5'd16);
      service("t1", 3, 0, 200);
      check("t1_ncmd", ncmd, 3);
      check("t1_pd0", pds[0], mkpd(4'd15, 32'h1000));
      check("t1_pd1", pds[1], mkpd(4'd15, 32'h1100));
      check("t1_pd2", pds[2], mkpd(4'd7, 32'h1200));
      check("t1_done_after_last", done_cyc, last_rsp_cyc + 1);
      check("t1_busy_held", busy_bad, 0);
      check("t1_out_end", outstanding, 0);
      step();

      // T2: a transfer that would cross a 4 KB boundary
      start_xfer(32'h0F80, 24'd16, 5'd16);
      service("t2", 3, 0, 200);
      check("t2_ncmd", ncmd, SPLIT ? 2 : 1);
      check("t2_pd0", pds[0], SPLIT ? mkpd(4'd7, 32'h0F80) : mkpd(4'd15, 32'h0F80));
`ifdef DMA_RD_4K_SPLIT_EN
      check("t2_pd1", pds[1], mkpd(4'd7, 32'h1000));
`endif
      step();

      // T3: the credit limit stalls issue until a response frees credit
      start_xfer(32'h2000, 24'd64, 5'd16);
      rd_req_rdy = 1'b1;
      hs_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (rd_req_vld) hs_cnt++;
         step();
      end
      check("t3_hs_cnt", hs_cnt, 2);
      check("t3_vld_stall", rd_req_vld, 0);
      check("t3_out_full", outstanding, 2);
      rd_rsp_last = 1'b1;
      step();
      rd_rsp_last = 1'b0;
      check("t3_vld_resume", rd_req_vld, 1);
      check("t3_pd2", rd_req_pd, mkpd(4'd15, 32'h2200));
      step();
      service("t3", 3, 2, 200);
      check("t3_ncmd_rest", ncmd, 1);
      check("t3_pd3", pds[0], mkpd(4'd15, 32'h2300));
      step();

      // T4: an empty transfer
      start_xfer(32'h5000, 24'd0, 5'd16);
      check("t4_done", done, 1);
      check("t4_busy", busy, 0);
      check("t4_vld", rd_req_vld, 0);
      step();
      check("t4_done_once", done, 0);
      check("t4_busy2", busy, 0);
      check("t4_vld2", rd_req_vld, 0);

      // T6: a handshake coincides with rsp_last at outstanding=1; burst 0 selects 16
      start_xfer(32'h4000, 24'd32, 5'd0);
      rd_req_rdy = 1'b1;
      step();
      check("t6_vld", rd_req_vld, 1);
      check("t6_pd0", rd_req_pd, mkpd(4'd15, 32'h4000));
      step();
      check("t6_pd1", rd_req_pd, mkpd(4'd15, 32'h4100));
      check("t6_out1", outstanding, 1);
      rd_rsp_last = 1'b1;
      step();
      rd_rsp_last = 1'b0;
      rd_req_rdy  = 1'b0;
      check("t6_out_coincident", outstanding, 1);
      check("t6_vld_off", rd_req_vld, 0);
      rd_rsp_last = 1'b1;
      step();
      rd_rsp_last = 1'b0;
      check("t6_done", done, 1);
      check("t6_busy_drop", busy, 0);
      check("t6_out0", outstanding, 0);
      step();
      check("t6_done_once", done, 0);

      // T5: back-pressure holds the command; start while busy is ignored; reset mid-ISSUE
      start_xfer(32'h3000, 24'd32, 5'd16);
      check("t5_vld_late", rd_req_vld, 0);
      step();
      check("t5_vld_up", rd_req_vld, 1);
      pd_first = rd_req_pd;
      hold_bad = 0;
      for (int i = 0; i < 5; i++) begin
         start = (i == 1);
         base_addr   = 32'h9000;
         total_beats = 24'd5;
         burst_beats = 5'd4;
         step();
         start = 1'b0;
         if (!rd_req_vld || rd_req_pd !== pd_first) hold_bad++;
      end
      check("t5_hold", hold_bad, 0);
      check("t5_pd0", rd_req_pd, mkpd(4'd15, 32'h3000));
      rd_req_rdy = 1'b1;
      step();
      rd_req_rdy = 1'b0;
      check("t5_pd1", rd_req_pd, mkpd(4'd15, 32'h3100));
      check("t5_out1", outstanding, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_vld", rd_req_vld, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_out", outstanding, 0);
      step(); step();
      rst_n = 1'b1;
      step(); step();
      check("t5_no_replay_vld", rd_req_vld, 0);
      check("t5_no_replay_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
